// File: rtl/abuf_sched_pkg.sv
// Shared types and constants for the activation-buffer load/feed scheduler.
package abuf_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FEED,
    ST_FLUSH,
    ST_DONE
  } abuf_state_t;

  // Read latency of an RBUF: cycles spent in FLUSH before signalling completion.
  localparam int RD_LAT = 1;

endpackage

// File: rtl/rbuf_skew_gen.sv
// Read-strobe generator for one row buffer: row K reads during feed steps K .. K+L-1,
// producing the diagonal wavefront the systolic array expects.
module rbuf_skew_gen
  import abuf_sched_pkg::*;
#(
  parameter int K    = 0,
  parameter int TW   = 5,
  parameter int CNTW = 5
) (
  input  logic [TW-1:0]   t,
  input  logic [CNTW-1:0] L,
  output logic            rd_en
);

  localparam int XW = ((TW > CNTW) ? TW : CNTW) + 2;

  logic [XW-1:0] w_t;
  logic [XW-1:0] w_lo;
  logic [XW-1:0] w_hi;

  assign w_t  = XW'(t);
  assign w_lo = XW'(K);
  assign w_hi = XW'(L) + XW'(K);

  assign rd_en = (w_t >= w_lo) && (w_t < w_hi);

endmodule

// File: rtl/abuf_sched.sv
// Load/feed scheduler for NBUF activation row buffers: steers a column-major input
// stream round-robin into the buffers, then issues diagonally skewed read strobes.
// Optional feed stall input is enabled by defining ABUF_SCHED_STALL_EN.
module abuf_sched
  import abuf_sched_pkg::*;
#(
  parameter int NBUF    = 4,
  parameter int BUFSIZE = 16,
  parameter int CNTW    = $clog2(BUFSIZE + 1)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [CNTW-1:0] len,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [NBUF-1:0] wr_en,
  output logic [NBUF-1:0] rd_en,
  output logic [NBUF-1:0] row_valid,
  output logic            busy,
  output logic            done
`ifdef ABUF_SCHED_STALL_EN
  ,
  input  logic            feed_stall
`endif
);

  localparam int WW = $clog2(BUFSIZE * NBUF + 1);
  localparam int TW = $clog2(BUFSIZE + NBUF);
  localparam int SW = (NBUF > 1) ? $clog2(NBUF) : 1;

  abuf_state_t     r_state;
  abuf_state_t     w_next;
  logic [CNTW-1:0] r_len;
  logic [CNTW-1:0] w_lenClamp;
  logic [WW-1:0]   r_w;
  logic [WW-1:0]   w_wLast;
  logic [SW-1:0]   r_s;
  logic [TW-1:0]   r_t;
  logic [TW-1:0]   w_tNext;
  logic [TW-1:0]   w_tLast;
  logic [NBUF-1:0] r_rd;
  logic [NBUF-1:0] w_skew;
  logic [NBUF-1:0] r_rowValid;
  logic            r_done;
  logic            w_stall;
  logic            w_accept;
  logic            w_wrLast;

`ifdef ABUF_SCHED_STALL_EN
  assign w_stall = feed_stall && (r_state == ST_FEED);
`else
  assign w_stall = 1'b0;
`endif

  // Requested length is clamped to the buffer depth so counters never overflow.
  assign w_lenClamp = (len > CNTW'(BUFSIZE)) ? CNTW'(BUFSIZE) : len;
  assign w_wLast    = WW'(r_len) * WW'(NBUF) - WW'(1);
  assign w_tLast    = TW'(r_len) + TW'(NBUF) - TW'(2);
  assign w_accept   = (r_state == ST_LOAD) && in_valid;
  assign w_wrLast   = w_accept && (r_w == w_wLast);

  // One skew generator per row, all driven by the feed step about to be presented.
  for (genvar k = 0; k < NBUF; k++) begin : g_skew
    rbuf_skew_gen #(
      .K    (k),
      .TW   (TW),
      .CNTW (CNTW)
    ) u_skew (
      .t     (w_tNext),
      .L     (r_len),
      .rd_en (w_skew[k])
    );
  end

  // Next-state and step-counter logic; r_t doubles as the FLUSH latency counter.
  always_comb begin
    w_next  = r_state;
    w_tNext = r_t;
    case (r_state)
      ST_IDLE: begin
        w_tNext = '0;
        if (start) begin
          w_next = (w_lenClamp == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_tNext = '0;
        if (w_wrLast) begin
          w_next = ST_FEED;
        end
      end
      ST_FEED: begin
        if (!w_stall) begin
          if (r_t == w_tLast) begin
            w_next  = ST_FLUSH;
            w_tNext = '0;
          end else begin
            w_tNext = r_t + TW'(1);
          end
        end
      end
      ST_FLUSH: begin
        w_tNext = r_t + TW'(1);
        if (r_t == TW'(RD_LAT - 1)) begin
          w_next  = ST_DONE;
          w_tNext = '0;
        end
      end
      ST_DONE: begin
        w_next  = ST_IDLE;
        w_tNext = '0;
      end
      default: begin
        w_next  = ST_IDLE;
        w_tNext = '0;
      end
    endcase
  end

  // Combinational handshake and write steering; a word lands in buffer r_s when accepted.
  always_comb begin
    in_ready = 1'b0;
    wr_en    = '0;
    busy     = 1'b0;
    if (r_state == ST_LOAD) begin
      in_ready = 1'b1;
    end
    if (w_accept) begin
      wr_en = NBUF'(1) << r_s;
    end
    if ((r_state == ST_LOAD) || (r_state == ST_FEED) || (r_state == ST_FLUSH)) begin
      busy = 1'b1;
    end
  end

  // State register and feed step counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_t     <= '0;
    end else begin
      r_state <= w_next;
      r_t     <= w_tNext;
    end
  end

  // Length latch plus write counter and round-robin buffer select.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_len <= '0;
      r_w   <= '0;
      r_s   <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_len <= w_lenClamp;
      r_w   <= '0;
      r_s   <= '0;
    end else if (w_accept) begin
      r_w <= r_w + WW'(1);
      r_s <= (r_s == SW'(NBUF - 1)) ? '0 : r_s + SW'(1);
    end
  end

  // Registered read strobes, their one-cycle-late row valids, and the completion pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd       <= '0;
      r_rowValid <= '0;
      r_done     <= 1'b0;
    end else begin
      r_rd       <= (w_next == ST_FEED) ? w_skew : '0;
      r_rowValid <= rd_en;
      r_done     <= (r_state == ST_DONE);
    end
  end

  assign rd_en     = r_rd & ~{NBUF{w_stall}};
  assign row_valid = r_rowValid;
  assign done      = r_done;

endmodule

// File: tb/tb_abuf_sched.sv
// Testbench for abuf_sched: directed and randomized transactions checked against
// a behavioural model of the write order, read wavefront and completion timing.
module tb_abuf_sched;

  localparam int NBUF    = 4;
  localparam int BUFSIZE = 16;
  localparam int CNTW    = $clog2(BUFSIZE + 1);

  logic            clk = 1'b0;
  logic            rstn;
  logic            start;
  logic [CNTW-1:0] len;
  logic            in_valid;
  logic            in_ready;
  logic [NBUF-1:0] wr_en;
  logic [NBUF-1:0] rd_en;
  logic [NBUF-1:0] row_valid;
  logic            busy;
  logic            done;
  logic            feed_stall;

  int nAssert = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  abuf_sched #(
    .NBUF    (NBUF),
    .BUFSIZE (BUFSIZE),
    .CNTW    (CNTW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .row_valid (row_valid),
    .busy      (busy),
    .done      (done)
`ifdef ABUF_SCHED_STALL_EN
    ,
    .feed_stall(feed_stall)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Which rows should be reading in FEED cycle c, given an optional stall window.
  function automatic logic [NBUF-1:0] expRd(input int c, input int L, input int S, input int stallAt);
    int t;
    logic [NBUF-1:0] r;
    r = '0;
    if (S > 0 && c >= stallAt && c < stallAt + S) return '0;
    t = (S > 0 && c >= stallAt + S) ? c - S : c;
    if (t > L + NBUF - 2) return '0;
    for (int k = 0; k < NBUF; k++) r[k] = (t >= k) && (t < k + L);
    return r;
  endfunction

  // One complete start/load/feed/done transaction with per-cycle checks.
  task automatic runTxn(input int lenReq, input int mode, input int stallAt, input int stallLen);
    int L, S, guard, writes, doneAt, lastBusy, cnt, firstDone;
    int rvCount[NBUF];
    logic [NBUF-1:0] prevRd, rdNow;
    L = (lenReq > BUFSIZE) ? BUFSIZE : lenReq;
    S = stallLen;
    $display("[TB] transaction len=%0d L=%0d mode=%0d stall=%0d@%0d", lenReq, L, mode, S, stallAt);
    start      = 1'b1;
    len        = CNTW'(lenReq);
    in_valid   = 1'b0;
    feed_stall = 1'b0;
    #1;
    check("idle_busy", busy, 0);
    tick;
    start = 1'b0;
    if (L == 0) begin
      cnt = 0;
      firstDone = -1;
      for (int i = 0; i < 4; i++) begin
        #1;
        check("zero_wr", wr_en, 0);
        check("zero_rd", rd_en, 0);
        if (done === 1'b1) begin
          cnt++;
          if (firstDone < 0) firstDone = i;
        end
        tick;
      end
      check("zero_done_count", cnt, 1);
      check("zero_done_prompt", (firstDone >= 0 && firstDone <= 1), 1);
      return;
    end
    writes = 0;
    guard  = 0;
    while (writes < L * NBUF && guard < 4 * L * NBUF + 8) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (guard % 2 == 1);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      #1;
      check("load_ready", in_ready, 1);
      check("load_busy", busy, 1);
      check("load_wr", wr_en, in_valid ? (32'd1 << (writes % NBUF)) : 32'd0);
      check("load_rd", rd_en, 0);
      if (in_valid) writes++;
      tick;
      guard++;
    end
    check("load_writes", writes, L * NBUF);
    prevRd   = '0;
    for (int k = 0; k < NBUF; k++) rvCount[k] = 0;
    doneAt   = L + NBUF + 1 + S;
    lastBusy = L + NBUF - 1 + S;
    for (int c = 0; c <= doneAt + 1; c++) begin
      in_valid   = 1'($urandom_range(0, 1));
      feed_stall = (S > 0 && c >= stallAt && c < stallAt + S);
      #1;
      rdNow = expRd(c, L, S, stallAt);
      check("feed_rd", rd_en, rdNow);
      check("feed_rowvalid", row_valid, prevRd);
      check("feed_wr", wr_en, 0);
      check("feed_ready", in_ready, 0);
      check("feed_busy", busy, (c <= lastBusy));
      check("feed_done", done, (c == doneAt));
      for (int k = 0; k < NBUF; k++) if (row_valid[k] === 1'b1) rvCount[k]++;
      prevRd = rdNow;
      tick;
    end
    feed_stall = 1'b0;
    in_valid   = 1'b0;
    for (int k = 0; k < NBUF; k++) check("rowvalid_len", rvCount[k], L);
  endtask

  initial begin
    rstn       = 1'b0;
    start      = 1'b0;
    len        = '0;
    in_valid   = 1'b0;
    feed_stall = 1'b0;
    repeat (3) tick;
    #1;
    check("rst_ready", in_ready, 0);
    check("rst_wr", wr_en, 0);
    check("rst_rd", rd_en, 0);
    check("rst_rowvalid", row_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rstn = 1'b1;
    tick;

    runTxn(0, 0, -1, 0);
    runTxn(4, 0, -1, 0);
    runTxn(4, 1, -1, 0);
    runTxn(20, 0, -1, 0);

    $display("[TB] reset in the middle of FEED");
    start    = 1'b1;
    len      = CNTW'(4);
    in_valid = 1'b1;
    tick;
    start = 1'b0;
    repeat (16) tick;
    in_valid = 1'b0;
    tick;
    tick;
    #1;
    check("midrst_pre_rd", rd_en, 4'b0111);
    rstn = 1'b0;
    #1;
    check("midrst_ready", in_ready, 0);
    check("midrst_wr", wr_en, 0);
    check("midrst_rd", rd_en, 0);
    check("midrst_rowvalid", row_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    tick;
    rstn = 1'b1;
    tick;
    runTxn(2, 0, -1, 0);

`ifdef ABUF_SCHED_STALL_EN
    runTxn(4, 0, 2, 3);
    runTxn(3, 2, 4, 2);
`endif

    for (int i = 0; i < 6; i++) begin
      runTxn(int'($urandom_range(0, 20)), int'($urandom_range(0, 2)), -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/abuf_sched.md
# abuf_sched

Load/feed scheduler for a bank of `NBUF` activation row buffers (RBUF instances, one per systolic-array row). It accepts one column-major input stream and steers each word to the correct buffer. It then issues diagonally skewed read strobes so that row k starts k cycles after row 0, which is the wavefront the systolic array requires. Data never passes through this block: `din` is broadcast to all buffers, and this block drives only their `write`/`read` strobes and the array's per-row valids.

## Interface
Parameters:
- `NBUF`, 4, number of row buffers / array rows
- `BUFSIZE`, 16, depth of each RBUF in words
- `CNTW`, $clog2(BUFSIZE+1), width of the length field

Ports:
- `clk`  in  1  single clock, rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle request; accepted only in IDLE
- `len`  in  CNTW  words per buffer; sampled on an accepted `start`
- `in_valid`  in  1  input word present on the shared `din` bus
- `in_ready`  out  1  scheduler accepts a word this cycle
- `wr_en`  out  NBUF  one-hot RBUF `write` strobes
- `rd_en`  out  NBUF  RBUF `read` strobes
- `row_valid`  out  NBUF  RBUF `dout` valid toward array row k
- `busy`  out  1  high in LOAD, FEED and FLUSH
- `done`  out  1  one-cycle completion pulse
- `feed_stall`  in  1  present only with `ABUF_SCHED_STALL_EN`

## Operation
- States: IDLE, LOAD, FEED, FLUSH, DONE.
- **IDLE:** on `start`, latch `L = min(len, BUFSIZE)`.
  - If `L == 0`, go to DONE.
  - Otherwise go to LOAD and clear the write counter `w` and the buffer select `s`.
  - `start` in any other state is ignored.
- **LOAD:**
  - `in_ready = 1`.
  - Word accepted when `in_valid & in_ready`; then `wr_en = 1 << s`, `s` advances round-robin mod `NBUF`, and `w` increments.
  - After word number `L*NBUF` is accepted, go to FEED.
- **FEED:**
  - Feed counter `t` runs from 0 to `L+NBUF-2`, one step per cycle.
  - `rd_en[k] = (t >= k) && (t < k+L)`.
  - After `t = L+NBUF-2`, go to FLUSH.
- **FLUSH:** one cycle that covers the RBUF read latency (`RD_LAT = 1`); then go to DONE.
- **DONE:** `done = 1` for one cycle; then go to IDLE.
- `row_valid` is `rd_en` registered once, so it lines up with RBUF `dout`.
- Counter widths: `w` is $clog2(BUFSIZE*NBUF+1) bits, `t` is $clog2(BUFSIZE+NBUF) bits, `s` is $clog2(NBUF) bits. No counter wraps during legal operation.
- **Reset mid-operation:**
  - All state and outputs go to 0 or IDLE immediately.
  - RBUF contents are not cleared by this block.

## Timing
- Reset values: `in_ready=0`, `wr_en=0`, `rd_en=0`, `row_valid=0`, `busy=0`, `done=0`.
- `in_ready` and `wr_en` are combinational from the state and `in_valid`. `rd_en`, `row_valid` and `done` are registered.
- An accepted `start` gives `busy = 1` on the next cycle.
- The first FEED cycle is the cycle after the last LOAD write.
- FEED lasts `L+NBUF-1` cycles. `done` asserts `L+NBUF+1` cycles after FEED entry (FEED cycle 0 is cycle 0).
- `row_valid[k]` is high for exactly `L` consecutive cycles, starting at FEED cycle `k+1`.

## Configuration
- `ABUF_SCHED_STALL_EN` defined:
  - Port `feed_stall` exists.
  - While `feed_stall = 1` in FEED, `t` holds and `rd_en = 0`. `row_valid` drops one cycle later.
  - Feeding resumes with the same `t` once `feed_stall` falls.
  - `feed_stall` is ignored in all other states.
- `ABUF_SCHED_STALL_EN` not defined: no port; FEED runs uninterrupted.

## Structure
- Package `abuf_sched_pkg`:
  - state enum typedef `abuf_state_t`
  - localparam `RD_LAT = 1`
- Sub-module `rbuf_skew_gen`:
  - inputs: `t`, `L`, row index `k` (parameter)
  - output: one `rd_en` bit
  - instantiated `NBUF` times by a generate loop

## Test plan
- Reset held, then released → all outputs 0, `busy = 0`; `start` with `len = 0` → `done` pulses the next cycle, with no `wr_en` or `rd_en` activity.
- `NBUF = 4`, `len = 4`, `in_valid` held high:
  - `wr_en` repeats 0001, 0010, 0100, 1000 four times (16 writes).
  - In FEED, `rd_en[0]` is high at t = 0..3 and `rd_en[3]` at t = 3..6.
  - `done` asserts 9 cycles after FEED entry (cycle 0 = FEED entry).
- `in_valid` toggled every other cycle during LOAD → exactly 16 writes, each to the correct buffer in round-robin order; FEED timing unchanged relative to the last write.
- `len = 20` with `BUFSIZE = 16` → clamped to `L = 16`: 64 writes, each `row_valid[k]` high for 16 cycles.
- `rstn` pulsed low at FEED t = 2, then `start` with `len = 2` → clean new LOAD of 8 words; no stale `rd_en`.
- With `ABUF_SCHED_STALL_EN`, `feed_stall` high at t = 2 for 3 cycles → `rd_en = 0` during the stall and the `done` pulse is delayed by exactly 3 cycles.
